// File: rtl/tuart_pkg.sv
// Shared UART types and frame constants for tuart_tx / tuart_rx.
// Optional parity bit enabled by defining TUART_TX_PARITY_EN.
package tuart_pkg;

  localparam int unsigned StartBits = 1;
  localparam int unsigned StopBits  = 1;

`ifdef TUART_TX_PARITY_EN
  localparam int unsigned ParityBits = 1;
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tuart_state_e;
`else
  localparam int unsigned ParityBits = 0;
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} tuart_state_e;
`endif

  function automatic int unsigned frame_bits(int unsigned word_bits);
    return StartBits + word_bits + ParityBits + StopBits;
  endfunction

endpackage

// File: rtl/tuart_tx_if.sv
// Request/response bundle between a SUMP core (master) and the UART transmitter (slave).
interface tuart_tx_if #(
  parameter int unsigned WORD_BITS  = 8,
  parameter int unsigned XMIT_WORDS = 4
);
  logic [WORD_BITS*XMIT_WORDS-1:0]   data_i;
  logic [$clog2(XMIT_WORDS+1)-1:0]   words_i;
  logic                              stb_i;
  logic                              ready_o;
  logic                              tx_o;

  modport master (output data_i, words_i, stb_i, input ready_o, tx_o);
  modport slave  (input data_i, words_i, stb_i, output ready_o, tx_o);
endinterface

// File: rtl/tuart_baud_cnt.sv
// Bit-time counter: counts 0..CLK_PER_SAMPLE-1, ticks on the last cycle of each bit.
module tuart_baud_cnt #(
  parameter int unsigned CLK_PER_SAMPLE = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CntW = $clog2(CLK_PER_SAMPLE + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(CLK_PER_SAMPLE - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tuart_tx.sv
// Multi-word UART transmitter: sends words_i words of data_i, LSB word first, 8N1-style frames.
// Defining TUART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module tuart_tx
  import tuart_pkg::*;
#(
  parameter int unsigned WORD_BITS      = 8,
  parameter int unsigned XMIT_WORDS     = 4,
  parameter int unsigned CLK_PER_SAMPLE = 10
) (
  input  logic       clk_i,
  input  logic       rst_in,
  tuart_tx_if.slave  bus
);
  localparam int unsigned DataW  = WORD_BITS * XMIT_WORDS;
  localparam int unsigned WordsW = $clog2(XMIT_WORDS + 1);
  localparam int unsigned BitW   = $clog2(WORD_BITS + 1);

  tuart_state_e          state_q, state_d;
  logic [DataW-1:0]      data_q, data_d;
  logic [WordsW-1:0]     words_q, words_d;
  logic [WordsW-1:0]     word_idx_q, word_idx_d;
  logic [BitW-1:0]       bit_idx_q, bit_idx_d;
  logic [WORD_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic [WORD_BITS-1:0]  cur_word;
  logic                  clr, tick;

  tuart_baud_cnt #(
    .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
  ) u_baud_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_in),
    .clr_i (clr),
    .tick_o(tick)
  );

  // Constant-index mux keeps the word select free of variable part-selects.
  always_comb begin
    cur_word = '0;
    for (int unsigned i = 0; i < XMIT_WORDS; i++) begin
      if (word_idx_q == WordsW'(i)) cur_word = data_q[i*WORD_BITS +: WORD_BITS];
    end
  end

  // tx_d is derived alongside the next state so the line flop changes on the same edge.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    words_d    = words_q;
    word_idx_d = word_idx_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    clr        = 1'b0;
    case (state_q)
      StIdle: begin
        clr  = 1'b1;
        tx_d = 1'b1;
        if (bus.stb_i && (bus.words_i != '0)) begin
          data_d     = bus.data_i;
          words_d    = bus.words_i;
          word_idx_d = '0;
          state_d    = StStart;
          tx_d       = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
          tx_d      = cur_word[0];
          shift_d   = cur_word >> 1;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_idx_q == BitW'(WORD_BITS - 1)) begin
`ifdef TUART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = ^cur_word;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BitW'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef TUART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if ((word_idx_q + WordsW'(1)) < words_q) begin
            word_idx_d = word_idx_q + WordsW'(1);
            state_d    = StStart;
            tx_d       = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      data_q     <= '0;
      words_q    <= '0;
      word_idx_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      words_q    <= words_d;
      word_idx_q <= word_idx_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx_o    = tx_q;
  assign bus.ready_o = (state_q == StIdle);
endmodule

// File: tb/tb_tuart_tx.sv
// Scoreboard bench for tuart_tx: stimulus pushes expected UART frames, a line monitor decodes them.
module tb_tuart_tx;
  localparam int WB  = 8;
  localparam int XW  = 4;
  localparam int CPS = 10;
`ifdef TUART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = WB + 2 + PB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tuart_tx_if #(.WORD_BITS(WB), .XMIT_WORDS(XW)) bus ();

  tuart_tx #(
    .WORD_BITS     (WB),
    .XMIT_WORDS    (XW),
    .CLK_PER_SAMPLE(CPS)
  ) dut (
    .clk_i (clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Line image of one word, bit 0 first on the wire.
  function automatic logic [15:0] frame_of(input logic [7:0] b);
    logic [15:0] f;
    f = '0;
    f[8:1] = b;
    if (PB != 0) f[9] = ^b;
    f[FB-1] = 1'b1;
    return f;
  endfunction

  // Monitor: every bit must hold for exactly CPS samples.
  logic [15:0] mon_got;
  logic        mon_stable;
  logic        mon_abort;
  always begin
    @(negedge clk);
    if (rst_n && bus.tx_o == 1'b0) begin
      mon_got    = '0;
      mon_stable = 1'b1;
      mon_abort  = 1'b0;
      for (int b = 0; b < FB && !mon_abort; b++) begin
        for (int s = 0; s < CPS && !mon_abort; s++) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (!rst_n) mon_abort = 1'b1;
          else if (s == 0) mon_got[b] = bus.tx_o;
          else if (bus.tx_o != mon_got[b]) mon_stable = 1'b0;
        end
      end
      if (!mon_abort) begin
        check("bit_stable", mon_stable, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_unexpected: got %0h, expected no frame", mon_got);
        end else begin
          check("frame", mon_got, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input int w, input int inj_at, input int rst_at);
    int cnt;
    cnt = 0;
    while (!bus.ready_o && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.ready_o) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.data_i  = d;
    bus.words_i = 3'(w);
    bus.stb_i   = 1'b1;
    @(posedge clk);
    #1 bus.stb_i = 1'b0;
    for (int i = 0; i < w; i++) exp_q.push_back(frame_of(d[i*8 +: 8]));
    @(negedge clk);
    check("tx_fall", bus.tx_o, 0);
    check("ready_drop", bus.ready_o, 0);
    cnt = 1;
    while (cnt < 5000) begin
      @(negedge clk);
      bus.stb_i = 1'b0;
      if (bus.ready_o) break;
      cnt++;
      if (cnt == inj_at) begin
        bus.data_i  = ~d;
        bus.words_i = 3'(XW);
        bus.stb_i   = 1'b1;
      end
      if (cnt == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx_async", bus.tx_o, 1);
        check("reset_ready_async", bus.ready_o, 1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check("busy_cycles", cnt, w * FB * CPS);
  endtask

  initial begin
    int bad;
    int rw;
    logic [31:0] rd;
    bus.stb_i   = 1'b0;
    bus.data_i  = '0;
    bus.words_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", bus.ready_o, 1);
    check("reset_tx", bus.tx_o, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(32'h0000_0055, 1, -1, -1);
    send(32'h4433_2211, 4, -1, -1);
    send(32'h0000_0007, 1, -1, -1);
    send(32'h0000_00A5, 1, 50, -1);
    send(32'h0000_C33C, 2, -1, 35);

    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (!bus.tx_o || !bus.ready_o) bad++;
    end
    check("silence_after_reset", bad, 0);

    bus.data_i  = 32'hFFFF_FFFF;
    bus.words_i = '0;
    bus.stb_i   = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bus.stb_i = 1'b0;
      if (!bus.tx_o || !bus.ready_o) bad++;
    end
    check("words0_ignored", bad, 0);

    for (int k = 0; k < 8; k++) begin
      rw = int'($urandom_range(1, XW));
      rd = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rd, rw, -1, -1);
    end

    repeat (50) @(negedge clk);
    check("leftover_frames", exp_q.size(), 0);
    check("final_idle_tx", bus.tx_o, 1);
    check("final_ready", bus.ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tuart_tx.md
TUART_TX -- requirements
Module: tuart_tx

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 8: data bits per UART word.
REQ-002 The block SHALL have parameter XMIT_WORDS, default 4: maximum words per response (one SUMP sample).
REQ-003 The block SHALL have parameter CLK_PER_SAMPLE, default 10: clk_i cycles per bit time.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_i, input, WORD_BITS*XMIT_WORDS bits: response payload; word 0 = data_i[WORD_BITS-1:0].
REQ-007 The block SHALL have port words_i, input, $clog2(XMIT_WORDS+1) bits: number of words to send, 0..XMIT_WORDS.
REQ-008 The block SHALL have port stb_i, input, 1 bit: start request, single-cycle strobe.
REQ-009 The block SHALL have port ready_o, output, 1 bit: high when idle and able to accept stb_i.
REQ-010 The block SHALL have port tx_o, output, 1 bit: serial UART line, idle high.

Function
REQ-011 The block SHALL use frame format 1 start bit (0), WORD_BITS data bits LSB first, then 1 stop bit (1), each bit lasting exactly CLK_PER_SAMPLE cycles.
REQ-012 The block SHALL implement FSM states IDLE, START, DATA, PARITY and STOP, where PARITY exists only with TUART_TX_PARITY_EN.
REQ-013 In IDLE, when stb_i=1 and words_i!=0, the block SHALL latch data_i and words_i, deassert ready_o, and enter START; tx_o falls on the clock edge after acceptance.
REQ-014 The block SHALL ignore stb_i with words_i=0: it stays in IDLE and ready_o stays high.
REQ-015 The block SHALL ignore stb_i while ready_o=0, without corrupting the latched payload.
REQ-016 On START expiry the block SHALL enter DATA with bit counter 0; it shifts one bit per bit time and, after bit WORD_BITS-1, enters PARITY (if enabled) or STOP.
REQ-017 On STOP expiry, if words remain, the block SHALL go directly to START with the next word (word index +1, no idle gap).
REQ-018 On STOP expiry of the last word the block SHALL enter IDLE and assert ready_o in the same edge.
REQ-019 Total busy time SHALL be words_i*(WORD_BITS+2)*CLK_PER_SAMPLE cycles, or words_i*(WORD_BITS+3)*CLK_PER_SAMPLE with parity.
REQ-020 The block SHALL back-to-back restart when stb_i=1 in the cycle ready_o rises: the next START follows immediately.
REQ-021 tx_o SHALL be driven from a flop and be glitch-free.
REQ-022 The bit-time counter SHALL be width $clog2(CLK_PER_SAMPLE+1) and wrap to 0 at CLK_PER_SAMPLE-1.

Reset
REQ-023 While rst_in=0 the block SHALL force, asynchronously, state IDLE, tx_o=1, ready_o=1, all counters 0 and the payload register 0.
REQ-024 On reset mid-frame the block SHALL abort the frame immediately (line high) and send no partial remainder after release.

Configuration
REQ-025 With macro TUART_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the data bits) between the last data bit and stop.
REQ-026 Without TUART_TX_PARITY_EN the block SHALL not contain the PARITY state or its logic.

Structure
REQ-027 Package tuart_pkg SHALL hold the FSM state enum and the frame-length constants shared with tuart_rx.
REQ-028 Sub-module tuart_baud_cnt SHALL provide the bit-time counter with clear and tick outputs.

Verification (WORD_BITS=8, XMIT_WORDS=4, CLK_PER_SAMPLE=10)
REQ-029 Bench SHALL drive data_i=0x55, words_i=1, stb_i pulse -> tx_o 0 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then 1 for 10 cycles; ready_o returns high 100 cycles after acceptance.
REQ-030 Bench SHALL drive data_i=0x44332211, words_i=4 -> bytes 0x11,0x22,0x33,0x44 sent contiguously, with ready_o low for exactly 400 cycles.
REQ-031 Bench SHALL pulse stb_i at cycle 50 of a busy frame with different data -> no change to tx_o waveform, and no extra frame afterwards.
REQ-032 Bench SHALL pull rst_in low at cycle 35 of a frame -> tx_o=1 and ready_o=1 immediately, then silence after release.
REQ-033 Bench SHALL drive stb_i with words_i=0 -> tx_o stays 1 and ready_o stays 1.
REQ-034 Bench SHALL build with TUART_TX_PARITY_EN, send 0x07 -> parity bit 1 after bit 7, ready_o low for 110 cycles.
